mem_issue_queue: RTL and testbench

//  In-order load/store queue feeding the two-stage memory unit (address stage, then RAM stage).

---
 rtl/mem_issue_queue.sv | 157 +++++++++++++++
 tb/tb_mem_issue_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_issue_queue.sv
// In-order load/store queue in front of the two-stage memory unit.
// Buffers issued memory ops and dispatches at most one per cycle.
module mem_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int PTR_W   = 2,
  parameter int MEM_LAT = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iss_lsq_valid,
  input  logic        iss_lsq_readmem,
  input  logic        iss_lsq_writemem,
  input  logic [31:0] iss_lsq_rega,
  input  logic [31:0] iss_lsq_imedext,
  input  logic [31:0] iss_lsq_regb,
  input  logic [4:0]  iss_lsq_regdest,
  input  logic        iss_lsq_writereg,
  input  logic        lsq_hold,
  output logic        lsq_iss_stall,
  output logic        lsq_mem_oper,
  output logic        lsq_mem_readmem,
  output logic        lsq_mem_writemem,
  output logic [31:0] lsq_mem_rega,
  output logic [31:0] lsq_mem_imedext,
  output logic [31:0] lsq_mem_regb,
  output logic [4:0]  lsq_mem_regdest,
  output logic        lsq_mem_writereg,
  output logic [1:0]  lsq_inflight,
  output logic        lsq_drained,
  output logic        lsq_err
);

  typedef struct packed {
    logic        readmem;
    logic        writemem;
    logic [31:0] rega;
    logic [31:0] imedext;
    logic [31:0] regb;
    logic [4:0]  regdest;
    logic        writereg;
  } lsq_entry_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  lsq_entry_t       q [DEPTH];
  lsq_entry_t       in_entry;
  lsq_entry_t       head_entry;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count;
  logic [MEM_LAT-1:0] sr;
  logic             legal;
  logic             enq;
  logic             deq;
  logic [1:0]       inflight_c;

  // Pack the incoming op and look at the current head entry.
  always_comb begin
    in_entry = '{
      readmem:  iss_lsq_readmem,
      writemem: iss_lsq_writemem,
      rega:     iss_lsq_rega,
      imedext:  iss_lsq_imedext,
      regb:     iss_lsq_regb,
      regdest:  iss_lsq_regdest,
      writereg: iss_lsq_writereg
    };
    head_entry = q[head];
  end

  // Stall comes from the registered count, so a full queue
  // blocks enqueue even when a dispatch frees a slot this cycle.
  always_comb begin
    lsq_iss_stall = (count == FULL);
    legal         = iss_lsq_readmem ^ iss_lsq_writemem;
    enq           = iss_lsq_valid & ~lsq_iss_stall & legal;
    deq           = ~lsq_hold & (count != '0);
  end

  // Entry storage; written at tail on enqueue.
  always_ff @(posedge clock) begin
    if (enq) q[tail] <= in_entry;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + 1'b1;
      if (deq) head <= head + 1'b1;
      if (enq && !deq)
        count <= count + 1'b1;
      else if (deq && !enq)
        count <= count - 1'b1;
    end
  end

  // Dispatch register; data fields hold when idle,
  // control fields drop so the memory unit sees a bubble.
  always_ff @(posedge clock) begin
    if (reset) begin
      lsq_mem_oper     <= 1'b0;
      lsq_mem_readmem  <= 1'b0;
      lsq_mem_writemem <= 1'b0;
      lsq_mem_rega     <= '0;
      lsq_mem_imedext  <= '0;
      lsq_mem_regb     <= '0;
      lsq_mem_regdest  <= '0;
      lsq_mem_writereg <= 1'b0;
    end else if (deq) begin
      lsq_mem_oper     <= 1'b1;
      lsq_mem_readmem  <= head_entry.readmem;
      lsq_mem_writemem <= head_entry.writemem;
      lsq_mem_rega     <= head_entry.rega;
      lsq_mem_imedext  <= head_entry.imedext;
      lsq_mem_regb     <= head_entry.regb;
      lsq_mem_regdest  <= head_entry.regdest;
      lsq_mem_writereg <= head_entry.writereg;
    end else begin
      lsq_mem_oper     <= 1'b0;
      lsq_mem_readmem  <= 1'b0;
      lsq_mem_writemem <= 1'b0;
      lsq_mem_writereg <= 1'b0;
    end
  end

  // Malformed op (neither or both of load/store) flags for one cycle.
  always_ff @(posedge clock) begin
    if (reset)
      lsq_err <= 1'b0;
    else
      lsq_err <= iss_lsq_valid & ~legal;
  end

  // Shadow of the memory unit's register stages.
  always_ff @(posedge clock) begin
    if (reset)
      sr <= '0;
    else if (MEM_LAT > 1)
      sr <= {sr[MEM_LAT-2:0], lsq_mem_oper};
    else
      sr <= MEM_LAT'(lsq_mem_oper);
  end

  // Ops in the dispatch register plus those inside the memory unit.
  always_comb begin
    inflight_c = 2'(lsq_mem_oper);
    for (int i = 0; i < MEM_LAT; i++)
      inflight_c = inflight_c + 2'(sr[i]);
    lsq_inflight = inflight_c;
    lsq_drained  = (count == '0) & (inflight_c == 2'd0);
  end

endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed bench for mem_issue_queue.
// Expected values are hand-derived from the queue's cycle behaviour.
module tb_mem_issue_queue;

  logic        clock = 1'b0;
  logic        reset;
  logic        iss_lsq_valid;
  logic        iss_lsq_readmem;
  logic        iss_lsq_writemem;
  logic [31:0] iss_lsq_rega;
  logic [31:0] iss_lsq_imedext;
  logic [31:0] iss_lsq_regb;
  logic [4:0]  iss_lsq_regdest;
  logic        iss_lsq_writereg;
  logic        lsq_hold;
  logic        lsq_iss_stall;
  logic        lsq_mem_oper;
  logic        lsq_mem_readmem;
  logic        lsq_mem_writemem;
  logic [31:0] lsq_mem_rega;
  logic [31:0] lsq_mem_imedext;
  logic [31:0] lsq_mem_regb;
  logic [4:0]  lsq_mem_regdest;
  logic        lsq_mem_writereg;
  logic [1:0]  lsq_inflight;
  logic        lsq_drained;
  logic        lsq_err;

  int n_run  = 0;
  int n_fail = 0;

  mem_issue_queue dut (
    .clock            (clock),
    .reset            (reset),
    .iss_lsq_valid    (iss_lsq_valid),
    .iss_lsq_readmem  (iss_lsq_readmem),
    .iss_lsq_writemem (iss_lsq_writemem),
    .iss_lsq_rega     (iss_lsq_rega),
    .iss_lsq_imedext  (iss_lsq_imedext),
    .iss_lsq_regb     (iss_lsq_regb),
    .iss_lsq_regdest  (iss_lsq_regdest),
    .iss_lsq_writereg (iss_lsq_writereg),
    .lsq_hold         (lsq_hold),
    .lsq_iss_stall    (lsq_iss_stall),
    .lsq_mem_oper     (lsq_mem_oper),
    .lsq_mem_readmem  (lsq_mem_readmem),
    .lsq_mem_writemem (lsq_mem_writemem),
    .lsq_mem_rega     (lsq_mem_rega),
    .lsq_mem_imedext  (lsq_mem_imedext),
    .lsq_mem_regb     (lsq_mem_regb),
    .lsq_mem_regdest  (lsq_mem_regdest),
    .lsq_mem_writereg (lsq_mem_writereg),
    .lsq_inflight     (lsq_inflight),
    .lsq_drained      (lsq_drained),
    .lsq_err          (lsq_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic op(input logic rd, input logic wr,
                    input logic [31:0] a, input logic [31:0] imm,
                    input logic [31:0] b, input logic [4:0] dst,
                    input logic wreg);
    iss_lsq_valid    = 1'b1;
    iss_lsq_readmem  = rd;
    iss_lsq_writemem = wr;
    iss_lsq_rega     = a;
    iss_lsq_imedext  = imm;
    iss_lsq_regb     = b;
    iss_lsq_regdest  = dst;
    iss_lsq_writereg = wreg;
  endtask

  task automatic idle();
    iss_lsq_valid    = 1'b0;
    iss_lsq_readmem  = 1'b0;
    iss_lsq_writemem = 1'b0;
  endtask

  task automatic wait_drained(input string tag);
    int n;
    n = 0;
    while (!lsq_drained && n < 10) begin
      tick();
      n++;
    end
    chk(tag, 32'(lsq_drained), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    lsq_hold = 1'b0;
    iss_lsq_rega = '0;
    iss_lsq_imedext = '0;
    iss_lsq_regb = '0;
    iss_lsq_regdest = '0;
    iss_lsq_writereg = 1'b0;
    op(1, 0, 32'h55, 0, 0, 5'd1, 1);

    // reset held two cycles with a valid op present
    tick();
    tick();
    chk("rst_oper", 32'(lsq_mem_oper), 32'd0);
    chk("rst_stall", 32'(lsq_iss_stall), 32'd0);
    chk("rst_drained", 32'(lsq_drained), 32'd1);
    chk("rst_inflight", 32'(lsq_inflight), 32'd0);
    chk("rst_err", 32'(lsq_err), 32'd0);
    chk("rst_rega", lsq_mem_rega, 32'd0);
    reset = 1'b0;
    idle();
    tick();
    chk("rst_noenq", 32'(lsq_mem_oper), 32'd0);
    chk("rst_noenq_dr", 32'(lsq_drained), 32'd1);

    // single load
    op(1, 0, 32'h100, 32'd4, 32'h0, 5'd3, 1);
    tick();
    idle();
    chk("ld_nobypass", 32'(lsq_mem_oper), 32'd0);
    chk("ld_q_dr", 32'(lsq_drained), 32'd0);
    tick();
    chk("ld_oper", 32'(lsq_mem_oper), 32'd1);
    chk("ld_rd", 32'(lsq_mem_readmem), 32'd1);
    chk("ld_wr", 32'(lsq_mem_writemem), 32'd0);
    chk("ld_rega", lsq_mem_rega, 32'h100);
    chk("ld_imm", lsq_mem_imedext, 32'd4);
    chk("ld_dst", 32'(lsq_mem_regdest), 32'd3);
    chk("ld_wreg", 32'(lsq_mem_writereg), 32'd1);
    chk("ld_inf0", 32'(lsq_inflight), 32'd1);
    tick();
    chk("ld_oper_off", 32'(lsq_mem_oper), 32'd0);
    chk("ld_rd_off", 32'(lsq_mem_readmem), 32'd0);
    chk("ld_rega_hold", lsq_mem_rega, 32'h100);
    chk("ld_inf1", 32'(lsq_inflight), 32'd1);
    tick();
    chk("ld_inf2", 32'(lsq_inflight), 32'd1);
    chk("ld_dr2", 32'(lsq_drained), 32'd0);
    tick();
    chk("ld_inf3", 32'(lsq_inflight), 32'd0);
    chk("ld_drained", 32'(lsq_drained), 32'd1);

    // fill with hold, then release
    lsq_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      op(0, 1, 32'h0, 32'h0, 32'(k), 5'd0, 0);
      chk("fill_prestall", 32'(lsq_iss_stall), 32'd0);
      tick();
    end
    chk("fill_stall", 32'(lsq_iss_stall), 32'd1);
    op(0, 1, 32'h0, 32'h0, 32'd5, 5'd0, 0);
    tick();
    chk("fill_held", 32'(lsq_iss_stall), 32'd1);
    chk("fill_nooper", 32'(lsq_mem_oper), 32'd0);
    lsq_hold = 1'b0;
    tick();
    chk("fill_o1", 32'(lsq_mem_oper), 32'd1);
    chk("fill_b1", lsq_mem_regb, 32'd1);
    chk("fill_wr1", 32'(lsq_mem_writemem), 32'd1);
    chk("fill_unstall", 32'(lsq_iss_stall), 32'd0);
    tick();
    idle();
    for (int k = 2; k <= 5; k++) begin
      if (k > 2) tick();
      chk("fill_oper", 32'(lsq_mem_oper), 32'd1);
      chk("fill_regb", lsq_mem_regb, 32'(k));
    end
    chk("fill_inf3", 32'(lsq_inflight), 32'd3);
    tick();
    chk("fill_end", 32'(lsq_mem_oper), 32'd0);
    chk("fill_inf2", 32'(lsq_inflight), 32'd2);
    wait_drained("fill_drained");

    // steady stream at occupancy 2
    lsq_hold = 1'b1;
    op(1, 0, 32'h10, 32'h0, 32'h0, 5'd7, 1);
    tick();
    op(1, 0, 32'h11, 32'h0, 32'h0, 5'd7, 1);
    tick();
    lsq_hold = 1'b0;
    for (int i = 0; i < 4; i++) begin
      op(1, 0, 32'h12 + 32'(i), 32'h0, 32'h0, 5'd7, 1);
      tick();
      chk("str_oper", 32'(lsq_mem_oper), 32'd1);
      chk("str_rega", lsq_mem_rega, 32'h10 + 32'(i));
      chk("str_stall", 32'(lsq_iss_stall), 32'd0);
    end
    idle();
    tick();
    chk("str_tail0", lsq_mem_rega, 32'h14);
    tick();
    chk("str_tail1", lsq_mem_rega, 32'h15);
    tick();
    chk("str_empty", 32'(lsq_mem_oper), 32'd0);
    wait_drained("str_drained");

    // malformed op then a legal one
    op(1, 1, 32'hdead, 32'h0, 32'h0, 5'd2, 1);
    chk("bad_err_pre", 32'(lsq_err), 32'd0);
    tick();
    chk("bad_err", 32'(lsq_err), 32'd1);
    chk("bad_drained", 32'(lsq_drained), 32'd1);
    op(1, 0, 32'h200, 32'h8, 32'h0, 5'd9, 1);
    tick();
    idle();
    chk("bad_err_off", 32'(lsq_err), 32'd0);
    chk("bad_noenq", 32'(lsq_mem_oper), 32'd0);
    tick();
    chk("good_oper", 32'(lsq_mem_oper), 32'd1);
    chk("good_rega", lsq_mem_rega, 32'h200);
    chk("good_dst", 32'(lsq_mem_regdest), 32'd9);
    tick();
    chk("good_once", 32'(lsq_mem_oper), 32'd0);
    wait_drained("bad_drained2");

    // reset with three queued and two in flight
    lsq_hold = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      op(0, 1, 32'(k), 32'h0, 32'(k), 5'd0, 0);
      tick();
    end
    lsq_hold = 1'b0;
    op(0, 1, 32'd5, 32'h0, 32'd5, 5'd0, 0);
    tick();
    tick();
    idle();
    lsq_hold = 1'b1;
    chk("mid_inf", 32'(lsq_inflight), 32'd2);
    chk("mid_regb", lsq_mem_regb, 32'd2);
    chk("mid_dr", 32'(lsq_drained), 32'd0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    lsq_hold = 1'b0;
    chk("mid_rst_oper", 32'(lsq_mem_oper), 32'd0);
    chk("mid_rst_inf", 32'(lsq_inflight), 32'd0);
    chk("mid_rst_dr", 32'(lsq_drained), 32'd1);
    chk("mid_rst_stall", 32'(lsq_iss_stall), 32'd0);
    tick();
    chk("mid_post_oper", 32'(lsq_mem_oper), 32'd0);
    chk("mid_post_dr", 32'(lsq_drained), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
